// File: rtl/lsu_defs_pkg.sv
// -----------------------------------------------------------------------------
// lsu_defs_pkg
//   Shared definitions for the load/store sequencer:
//     - access size codes in RV32I funct3 encoding
//     - FSM state encoding for lsu_ctrl
//     - byte-strobe base patterns (shifted by the byte offset for B/H)
//     - access_err(): alignment / legal-size check for one access
// -----------------------------------------------------------------------------
package lsu_defs_pkg;

    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    // Returns 1 when the access must be rejected without touching memory:
    // reserved size codes, unsigned sizes on stores, or a misaligned H/W.
    function automatic logic access_err(input logic       we,
                                        input logic [2:0] size,
                                        input logic [1:0] addr_lo);
        logic err;
        err = 1'b0;
        case (size)
            SZ_B, SZ_BU: err = 1'b0;
            SZ_H, SZ_HU: err = addr_lo[0];
            SZ_W:        err = (addr_lo != 2'b00);
            default:     err = 1'b1;
        endcase
        if (we && (size > SZ_W)) begin
            err = 1'b1;
        end
        return err;
    endfunction

endpackage

// File: rtl/lsu_ctrl_memsx.sv
// -----------------------------------------------------------------------------
// memsx
//   Combinational sign/zero extender for load data. The input word is already
//   lane-shifted so the addressed byte/halfword sits in the LSBs.
//   Ports:
//     mem_size   in  3   funct3 size code (B, H, W, BU, HU)
//     mem_value  in  32  lane-shifted read word
//     mem_extend out 32  extended result (reserved codes pass the word through)
// -----------------------------------------------------------------------------
module memsx
    import lsu_defs_pkg::*;
(
    input  logic [2:0]  mem_size,
    input  logic [31:0] mem_value,
    output logic [31:0] mem_extend
);

    logic signed [7:0]  w_byte_s;
    logic signed [15:0] w_half_s;

    assign w_byte_s = mem_value[7:0];
    assign w_half_s = mem_value[15:0];

    always_comb begin
        mem_extend = mem_value;
        case (mem_size)
            SZ_B:    mem_extend = 32'(w_byte_s);
            SZ_H:    mem_extend = 32'(w_half_s);
            SZ_BU:   mem_extend = {24'd0, mem_value[7:0]};
            SZ_HU:   mem_extend = {16'd0, mem_value[15:0]};
            default: mem_extend = mem_value;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl
//   Load/store sequencer between the RV32I core and the data memory port.
//   One access at a time: IDLE accepts and checks it, BUSY holds a word-aligned
//   memory request with byte strobes until mem_ack, RESP pulses the response.
//   Misaligned or illegal accesses go straight IDLE -> RESP with resp_err.
//
//   Optional feature macro: LSU_TIMEOUT_EN
//     defined   - BUSY aborts with resp_err after TIMEOUT cycles without mem_ack
//                 (an ack arriving in the limit cycle still completes normally)
//     undefined - BUSY waits for mem_ack indefinitely
//
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     req_valid/req_ready        core request handshake (ready only in IDLE)
//     req_we/size/addr/wdata     access description (size in funct3 encoding)
//     resp_valid/err/rdata       one-cycle response; rdata held until next one
//     mem_req/we/addr/wdata/wstrb memory request, stable while mem_req=1
//     mem_rdata/mem_ack          memory completion (rdata valid with ack)
// -----------------------------------------------------------------------------
module lsu_ctrl
    import lsu_defs_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    lsu_state_e  r_state;
    logic        r_ready;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_resp_rdata;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wstrb;
    logic [2:0]  r_size;
    logic [1:0]  r_addr_lo;

    logic        w_req_err;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_lane;
    logic [31:0] w_ext;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    // Counts the current BUSY cycle, so the limit hits in the TIMEOUT-th one.
    assign w_cnt_next = r_cnt + CNT_W'(1);
`else
    // TIMEOUT only matters when the abort counter is built in.
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT == 0);
`endif

    assign w_req_err = access_err(req_we, req_size, req_addr[1:0]);

    // Strobes and replicated store data; only used when the access is legal,
    // so H is always halfword aligned here.
    always_comb begin
        w_strb      = STRB_W;
        w_wdata_rep = req_wdata;
        case (req_size)
            SZ_B: begin
                w_strb      = STRB_B << req_addr[1:0];
                w_wdata_rep = {4{req_wdata[7:0]}};
            end
            SZ_H: begin
                w_strb      = STRB_H << req_addr[1:0];
                w_wdata_rep = {2{req_wdata[15:0]}};
            end
            default: begin
                w_strb      = STRB_W;
                w_wdata_rep = req_wdata;
            end
        endcase
    end

    // Move the addressed byte/halfword down to bit 0 before extension.
    assign w_lane = mem_rdata >> {r_addr_lo, 3'b000};

    memsx u_memsx (
        .mem_size   (r_size),
        .mem_value  (w_lane),
        .mem_extend (w_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wstrb  <= '0;
            r_size       <= SZ_B;
            r_addr_lo    <= '0;
`ifdef LSU_TIMEOUT_EN
            r_cnt        <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_ready   <= 1'b0;
                        r_size    <= req_size;
                        r_addr_lo <= req_addr[1:0];
                        if (w_req_err) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else begin
                            r_state     <= BUSY;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= req_we;
                            r_mem_addr  <= {req_addr[31:2], 2'b00};
                            r_mem_wdata <= w_wdata_rep;
                            r_mem_wstrb <= req_we ? w_strb : 4'b0000;
`ifdef LSU_TIMEOUT_EN
                            r_cnt       <= '0;
`endif
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        r_state      <= RESP;
                        r_mem_req    <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= r_mem_we ? 32'd0 : w_ext;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (w_cnt_next == CNT_W'(TIMEOUT)) begin
                        r_state      <= RESP;
                        r_mem_req    <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= '0;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
`endif
                end
                RESP: begin
                    r_state      <= IDLE;
                    r_resp_valid <= 1'b0;
                    r_ready      <= 1'b1;
                end
                default: begin
                    r_state      <= IDLE;
                    r_resp_valid <= 1'b0;
                    r_mem_req    <= 1'b0;
                    r_ready      <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_wstrb  = r_mem_wstrb;

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl
//   Directed bench for lsu_ctrl. A cycle-level expectation model (latency
//   rules plus arithmetic models of alignment, strobes, lane replication and
//   load extension) is compared against the DUT on every falling edge; a few
//   literal values pin the model. With LSU_TIMEOUT_EN defined the DUT is
//   built with TIMEOUT=8 and the abort path is exercised as well.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

    localparam int TB_TO = 8;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we    = 1'b0;
    logic [2:0]  req_size  = 3'd0;
    logic [31:0] req_addr  = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack   = 1'b0;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    lsu_ctrl #(.TIMEOUT(TB_TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    // Expected per-cycle outputs
    bit          chk_en         = 1'b0;
    logic        exp_ready      = 1'b1;
    logic        exp_mem_req    = 1'b0;
    logic        exp_resp_valid = 1'b0;
    logic        exp_err        = 1'b0;
    logic [31:0] exp_rdata      = 32'd0;
    logic        exp_we         = 1'b0;
    logic [31:0] exp_addr       = 32'd0;
    logic [31:0] exp_wdata      = 32'd0;
    logic [3:0]  exp_wstrb      = 4'd0;

    // DUT snapshots for literal checks
    logic [31:0] snap_addr  = 32'd0;
    logic [31:0] snap_wdata = 32'd0;
    logic [3:0]  snap_wstrb = 4'd0;
    logic        snap_err   = 1'b0;
    logic [31:0] snap_rdata = 32'd0;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_err(input logic we, input logic [2:0] size, input logic [31:0] addr);
        int nb;
        int off;
        if (size == 3'd3 || size >= 3'd6) return 1'b1;
        if (we && size > 3'd2) return 1'b1;
        nb  = 1 << (int'(size) % 4);
        off = int'(addr[1:0]);
        return (off % nb) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] size, input logic [31:0] addr,
                                               input logic [31:0] word);
        logic [31:0] w;
        int v;
        w = word >> (8 * int'(addr[1:0]));
        case (size)
            3'd0: begin
                v = int'(w & 32'hFF);
                if (v >= 128) v -= 256;
                return 32'(v);
            end
            3'd1: begin
                v = int'(w & 32'hFFFF);
                if (v >= 32768) v -= 65536;
                return 32'(v);
            end
            3'd4:    return w & 32'hFF;
            3'd5:    return w & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    task automatic set_mem_exp(input logic we, input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata);
        int nb;
        nb       = 1 << int'(size);
        exp_addr = addr & 32'hFFFF_FFFC;
        exp_we   = we;
        if (we) exp_wstrb = 4'(((1 << nb) - 1) << int'(addr[1:0]));
        else    exp_wstrb = 4'b0000;
        case (nb)
            1:       exp_wdata = 32'(wdata[7:0]) * 32'h0101_0101;
            2:       exp_wdata = 32'(wdata[15:0]) * 32'h0001_0001;
            default: exp_wdata = wdata;
        endcase
    endtask

    // One access from presentation to the ready cycle after its response.
    // k = cycles mem_req is high before the ack cycle; no_ack = let it time out.
    task automatic do_acc(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int k, input bit no_ack);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        step();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 3'd0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h0BAD_0BAD;
        exp_ready = 1'b0;
        if (model_err(we, size, addr)) begin
            exp_resp_valid = 1'b1;
            exp_err        = 1'b1;
            exp_rdata      = 32'd0;
        end else begin
            set_mem_exp(we, size, addr, wdata);
            exp_mem_req = 1'b1;
            if (no_ack) begin
                repeat (TB_TO) step();
                exp_mem_req    = 1'b0;
                exp_resp_valid = 1'b1;
                exp_err        = 1'b1;
                exp_rdata      = 32'd0;
            end else begin
                repeat (k) step();
                mem_ack    = 1'b1;
                mem_rdata  = rdata;
                snap_addr  = mem_addr;
                snap_wstrb = mem_wstrb;
                snap_wdata = mem_wdata;
                step();
                mem_ack        = 1'b0;
                mem_rdata      = 32'hA5A5_5A5A;
                exp_mem_req    = 1'b0;
                exp_resp_valid = 1'b1;
                exp_err        = 1'b0;
                exp_rdata      = we ? 32'd0 : model_load(size, addr, rdata);
            end
        end
        snap_err   = resp_err;
        snap_rdata = resp_rdata;
        step();
        exp_resp_valid = 1'b0;
        exp_ready      = 1'b1;
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("mem_req", 32'(mem_req), 32'(exp_mem_req));
            chk("resp_valid", 32'(resp_valid), 32'(exp_resp_valid));
            chk("resp_rdata", resp_rdata, exp_rdata);
            if (exp_resp_valid) chk("resp_err", 32'(resp_err), 32'(exp_err));
            if (exp_mem_req) begin
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_we", 32'(mem_we), 32'(exp_we));
                chk("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
                if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (2) step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        step();

        // LW, ack after 2 cycles
        do_acc(1'b0, 3'd2, 32'h100, 32'd0, 32'hDEAD_BEEF, 2, 1'b0);
        chk("lw_rdata_lit", snap_rdata, 32'hDEAD_BEEF);
        chk("lw_err_lit", 32'(snap_err), 32'd0);
        chk("lw_addr_lit", snap_addr, 32'h100);

        // LB / LBU from the top lane
        do_acc(1'b0, 3'd0, 32'h103, 32'd0, 32'h80FF_0000, 1, 1'b0);
        chk("lb_rdata_lit", snap_rdata, 32'hFFFF_FF80);
        do_acc(1'b0, 3'd4, 32'h103, 32'd0, 32'h80FF_0000, 0, 1'b0);
        chk("lbu_rdata_lit", snap_rdata, 32'h0000_0080);

        // SH to upper halfword, ack in the same cycle mem_req rises
        do_acc(1'b1, 3'd1, 32'h202, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, 1'b0);
        chk("sh_addr_lit", snap_addr, 32'h200);
        chk("sh_wstrb_lit", 32'(snap_wstrb), 32'(4'b1100));
        chk("sh_wdata_lit", snap_wdata, 32'hABCD_ABCD);
        chk("sh_rdata_lit", snap_rdata, 32'd0);

        // Error paths: no memory access, response next cycle
        do_acc(1'b0, 3'd2, 32'h101, 32'd0, 32'd0, 0, 1'b0);
        chk("lw_mis_err_lit", 32'(snap_err), 32'd1);
        do_acc(1'b0, 3'd1, 32'h103, 32'd0, 32'd0, 0, 1'b0);
        chk("lh_mis_err_lit", 32'(snap_err), 32'd1);
        do_acc(1'b0, 3'd3, 32'h100, 32'd0, 32'd0, 0, 1'b0);
        chk("size3_err_lit", 32'(snap_err), 32'd1);
        do_acc(1'b1, 3'd4, 32'h100, 32'h11, 32'd0, 0, 1'b0);
        do_acc(1'b0, 3'd5, 32'h001, 32'd0, 32'd0, 0, 1'b0);
        do_acc(1'b0, 3'd7, 32'h000, 32'd0, 32'd0, 0, 1'b0);

        // More legal patterns
        do_acc(1'b1, 3'd0, 32'h001, 32'hFFFF_FF55, 32'd0, 1, 1'b0);
        chk("sb_wstrb_lit", 32'(snap_wstrb), 32'(4'b0010));
        chk("sb_wdata_lit", snap_wdata, 32'h5555_5555);
        do_acc(1'b0, 3'd1, 32'h002, 32'd0, 32'h8001_1234, 1, 1'b0);
        chk("lh_rdata_lit", snap_rdata, 32'hFFFF_8001);
        do_acc(1'b0, 3'd5, 32'h002, 32'd0, 32'h8001_1234, 0, 1'b0);
        chk("lhu_rdata_lit", snap_rdata, 32'h0000_8001);
        do_acc(1'b0, 3'd0, 32'h000, 32'd0, 32'h1234_567F, 0, 1'b0);
        chk("lb_pos_lit", snap_rdata, 32'h0000_007F);
        do_acc(1'b1, 3'd2, 32'h010, 32'hCAFE_F00D, 32'd0, 3, 1'b0);
        chk("sw_wstrb_lit", 32'(snap_wstrb), 32'(4'b1111));
        do_acc(1'b0, 3'd2, 32'h014, 32'd0, 32'h1357_9BDF, TB_TO - 1, 1'b0);

        // mem_ack while idle is ignored
        mem_ack = 1'b1;
        repeat (2) step();
        mem_ack = 1'b0;
        step();

        // Reset in the middle of an access
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 3'd2;
        req_addr  = 32'h300;
        step();
        req_valid = 1'b0;
        exp_ready = 1'b0;
        set_mem_exp(1'b0, 3'd2, 32'h300, 32'd0);
        exp_mem_req = 1'b1;
        step();
        reset = 1'b1;
        step();
        reset       = 1'b0;
        exp_ready   = 1'b1;
        exp_mem_req = 1'b0;
        exp_rdata   = 32'd0;
        step();
        chk("rst_mid_addr", mem_addr, 32'd0);
        chk("rst_mid_rdata", resp_rdata, 32'd0);
        step();

`ifdef LSU_TIMEOUT_EN
        do_acc(1'b0, 3'd2, 32'h400, 32'd0, 32'd0, 0, 1'b1);
        chk("timeout_err_lit", 32'(snap_err), 32'd1);
        chk("timeout_rdata_lit", snap_rdata, 32'd0);
        do_acc(1'b0, 3'd2, 32'h404, 32'd0, 32'h2468_ACE0, TB_TO - 1, 1'b0);
        chk("ack_at_limit_lit", snap_rdata, 32'h2468_ACE0);
`endif

        step();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
